// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and counter-width helpers for the PLL lock sequencer
package pll_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABILIZE,
    RELEASE,
    RUN
  } seq_state_t;

  // Width of a counter that counts 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int stab_cnt_w(input int lock_stable);
    return cnt_w(lock_stable);
  endfunction

  function automatic int hold_cnt_w(input int rst_hold);
    return cnt_w(rst_hold);
  endfunction

  function automatic int div_cnt_w(input int div_b);
    return cnt_w(div_b);
  endfunction

endpackage

// File: rtl/pll_seq_ce_div.sv
// rtl/pll_seq_ce_div.sv - clock-enable divider producing ce_a / ce_b strobes
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   en     in  divider runs while high; held at zero (no strobes) while low
//   ce_a   out registered strobe, one cycle every DIV_A cycles
//   ce_b   out registered strobe, one cycle every DIV_B cycles, always with ce_a
module pll_seq_ce_div
  import pll_seq_pkg::*;
#(
  parameter int DIV_A = 2,
  parameter int DIV_B = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic ce_a,
  output logic ce_b
);

  localparam int DIV_W = div_cnt_w(DIV_B);

  logic [DIV_W-1:0] div_cnt;

  // Strobes are decoded from the pre-increment count, so the first ce_a
  // appears DIV_A edges after en rises.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      div_cnt <= '0;
      ce_a    <= 1'b0;
      ce_b    <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_W'(DIV_B - 1)) ? '0 : div_cnt + 1'b1;
      ce_a    <= ((int'(div_cnt) % DIV_A) == DIV_A - 1);
      ce_b    <= (div_cnt == DIV_W'(DIV_B - 1));
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL lock qualification, core reset release and clock enables
// Optional feature macro: PLL_SEQ_LOSS_CNT_EN (saturating lock-loss counter on loss_cnt)
// Ports:
//   clk         in  50 MHz system clock
//   rst_n       in  synchronous active-low reset
//   pll_locked  in  PLL lock flag, asynchronous to clk
//   sys_rst_n   out core reset, active low, registered
//   ce_a        out strobe every DIV_A cycles while released
//   ce_b        out strobe every DIV_B cycles while released
//   ready       out high in RUN
//   lock_lost   out one-cycle pulse when qualified lock drops in RELEASE/RUN
//   loss_cnt    out lock-loss count (zero unless PLL_SEQ_LOSS_CNT_EN)
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STABLE = 1024,
  parameter int RST_HOLD    = 16,
  parameter int DIV_A       = 2,
  parameter int DIV_B       = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  output logic             sys_rst_n,
  output logic             ce_a,
  output logic             ce_b,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam int STAB_W = stab_cnt_w(LOCK_STABLE);
  localparam int HOLD_W = hold_cnt_w(RST_HOLD);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  seq_state_t             state_q, state_d;
  logic [STAB_W-1:0]      stab_cnt;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   loss_d;
  logic                   div_en;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  always_comb begin
    state_d = state_q;
    loss_d  = 1'b0;
    case (state_q)
      WAIT_LOCK: if (lock_s) state_d = STABILIZE;
      STABILIZE: if (stab_cnt == STAB_W'(LOCK_STABLE - 1)) state_d = RELEASE;
      RELEASE:   if (hold_cnt == HOLD_W'(RST_HOLD - 1)) state_d = RUN;
      RUN:       state_d = RUN;
      default:   state_d = WAIT_LOCK;
    endcase
    // Losing lock overrides everything; only counts as a loss once released.
    if (state_q != WAIT_LOCK && !lock_s) begin
      state_d = WAIT_LOCK;
      loss_d  = (state_q == RELEASE) || (state_q == RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= WAIT_LOCK;
      stab_cnt  <= '0;
      hold_cnt  <= '0;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state_q   <= state_d;
      stab_cnt  <= (state_q == STABILIZE && state_d == STABILIZE) ? stab_cnt + 1'b1 : '0;
      hold_cnt  <= (state_q == RELEASE && state_d == RELEASE) ? hold_cnt + 1'b1 : '0;
      sys_rst_n <= (state_d == RUN);
      ready     <= (state_d == RUN);
      lock_lost <= loss_d;
    end
  end

  // Gating with lock_s makes the strobes drop on the same edge as lock_lost.
  assign div_en = ((state_q == RELEASE) || (state_q == RUN)) && lock_s;

  pll_seq_ce_div #(
    .DIV_A(DIV_A),
    .DIV_B(DIV_B)
  ) u_ce_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (div_en),
    .ce_a (ce_a),
    .ce_b (ce_b)
  );

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                       loss_q <= '0;
    else if (loss_d && loss_q != '1)  loss_q <= loss_q + 1'b1;
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

  localparam int SS = 2;
  localparam int LS = 4;
  localparam int RH = 3;
  localparam int DA = 2;
  localparam int DB = 8;
  localparam int CW = 2;
  localparam int LOSS_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          sys_rst_n, ce_a, ce_b, ready, lock_lost;
  logic [CW-1:0] loss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: lock samples delayed SS edges, run length of qualified lock
  int q_samp[$];
  int m_run  = 0;
  int m_loss = 0;
  logic e_rel, e_a, e_b, e_lost;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .SYNC_STAGES(SS), .LOCK_STABLE(LS), .RST_HOLD(RH),
    .DIV_A(DA), .DIV_B(DB), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .sys_rst_n(sys_rst_n), .ce_a(ce_a), .ce_b(ce_b),
    .ready(ready), .lock_lost(lock_lost), .loss_cnt(loss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic p);
    int obs, prev;
    if (!r) begin
      q_samp.delete();
      for (int i = 0; i < SS; i++) q_samp.push_back(0);
      m_run = 0; m_loss = 0;
      e_rel = 0; e_a = 0; e_b = 0; e_lost = 0;
    end else begin
      obs  = q_samp[0];
      prev = m_run;
      m_run = obs ? m_run + 1 : 0;
      e_lost = (obs == 0) && (prev >= LS + 1);
`ifdef PLL_SEQ_LOSS_CNT_EN
      if (e_lost && m_loss < LOSS_MAX) m_loss++;
`endif
      void'(q_samp.pop_front());
      q_samp.push_back(int'(p));
      e_rel = (m_run >= LS + RH + 1);
      e_a   = (m_run >= LS + 2) && (((m_run - LS - 2) % DA) == DA - 1);
      e_b   = (m_run >= LS + 2) && (((m_run - LS - 2) % DB) == DB - 1);
    end
  endtask

  task automatic step(input logic r, input logic p);
    rst_n = r;
    pll_locked = p;
    @(posedge clk);
    model_edge(r, p);
    #1;
    chk("sys_rst_n", sys_rst_n, e_rel);
    chk("ready", ready, e_rel);
    chk("ce_a", ce_a, e_a);
    chk("ce_b", ce_b, e_b);
    chk("lock_lost", lock_lost, e_lost);
    chk("loss_cnt", loss_cnt, m_loss);
    chk("ce_b_without_ce_a", ce_b & ~ce_a, 1'b0);
  endtask

  initial begin
    int first_rel, first_a, first_b, first_lost, lost_seen;
    int len;
    logic p;

    for (int i = 0; i < SS; i++) q_samp.push_back(0);

    // 1: reset held with no lock
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

    // 2: lock rises, i=0 is edge E
    first_rel = -1; first_a = -1; first_b = -1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1);
      if (sys_rst_n === 1'b1 && first_rel < 0) first_rel = i;
      if (ce_a === 1'b1 && first_a < 0) first_a = i;
      if (ce_b === 1'b1 && first_b < 0) first_b = i;
    end
    chk("release_latency", first_rel, 9);
    chk("first_ce_a", first_a, 8);
    chk("first_ce_b", first_b, 14);

    // 4: lock drops in RUN
    first_lost = -1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      if (lock_lost === 1'b1 && first_lost < 0) first_lost = i;
    end
    chk("lock_lost_delay", first_lost, 2);
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk("loss_cnt_first", loss_cnt, 1);
`else
    chk("loss_cnt_first", loss_cnt, 0);
`endif

    // 3: one-cycle glitch during STABILIZE
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    first_rel = -1; lost_seen = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1);
      if (lock_lost === 1'b1) lost_seen = 1;
      if (sys_rst_n === 1'b1 && first_rel < 0) first_rel = i;
    end
    chk("glitch_no_loss", lost_seen, 0);
    chk("glitch_restart_latency", first_rel, 9);

    // 5: five more losses from RUN
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
`ifdef PLL_SEQ_LOSS_CNT_EN
    chk("loss_cnt_saturated", loss_cnt, 3);
`else
    chk("loss_cnt_saturated", loss_cnt, 0);
`endif

    // 6: reset during RELEASE
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("rst_sys_rst_n", sys_rst_n, 0);
    chk("rst_ce_a", ce_a, 0);
    chk("rst_loss_cnt", loss_cnt, 0);
    first_rel = -1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1);
      if (sys_rst_n === 1'b1 && first_rel < 0) first_rel = i;
    end
    chk("post_reset_latency", first_rel, 9);

    // Random lock patterns with occasional reset
    for (int k = 0; k < 60; k++) begin
      p = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) step(($urandom_range(0, 39) != 0), p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
